nios2_pio_in_edge: RTL and testbench

NIOS2_PIO_IN_EDGE -- requirements
Module: nios2_pio_in_edge

---
 rtl/nios2_pio_in_edge.sv | 207 ++++++++++++++++++++
 tb/tb_nios2_pio_in_edge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
// Module   : nios2_pio_in_edge
// Purpose  : Avalon-MM parallel input port with per-bit synchroniser,
//            optional debounce, edge capture and level interrupt.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH           number of input bits (1..32)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   SYNC_STAGES     synchroniser depth per bit (2..4)
//   DEBOUNCE_CYCLES stability window in clk cycles (2..65535), only used
//                   when NIOS2_PIO_DEBOUNCE_EN is defined
// Ports
//   clk        in   single clock
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0]  word address (0 data, 1 reserved, 2 irqmask,
//                          3 edgecapture)
//   chipselect in   slave select
//   write_n    in   active-low write strobe, qualified by chipselect
//   writedata  in   [31:0]
//   in_port    in   [WIDTH-1:0] asynchronous external inputs
//   readdata   out  [31:0] registered read data, one cycle latency
//   irq        out  level interrupt, OR of (edgecapture & irqmask)
// Build option
//   NIOS2_PIO_DEBOUNCE_EN  adds a per-bit debounce filter after the
//                          synchroniser
// ============================================================================
module nios2_pio_in_edge #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_mask;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_next;

  // --------------------------------------------------------------------------
  // Synchroniser chain
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_ff[s] <= sync_ff[s-1];
      end
    end
  end

  assign sync_in = sync_ff[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Arming counter: edges are ignored until the synchroniser and prev hold
  // real input levels, so the level present at reset never looks like an edge.
  // --------------------------------------------------------------------------
  assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
`ifdef NIOS2_PIO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0]           db_val;
  logic [WIDTH-1:0][DB_W-1:0] db_cnt;

  // While unarmed the filter tracks sync_in directly so the reset-time level
  // is adopted without a debounce delay (which would otherwise show up as an
  // edge once arming completes).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_val <= '0;
      db_cnt <= '0;
    end else if (!armed) begin
      db_val <= sync_in;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_in[i] != db_val[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_val[i] <= sync_in[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign cond = db_val;

  logic unused_bits;
  assign unused_bits = &{1'b0, writedata};
`else
  assign cond = sync_in;

  logic unused_bits;
  assign unused_bits = &{1'b0, writedata, 32'(DEBOUNCE_CYCLES)};
`endif

  // prev follows sync_in while unarmed so that it matches cond at arming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else if (!armed) begin
      prev <= sync_in;
    end else begin
      prev <= cond;
    end
  end

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------
  if (EDGE_TYPE == 0) begin : g_rise
    assign raw_edge = cond & ~prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign raw_edge = ~cond & prev;
  end else begin : g_any
    assign raw_edge = cond ^ prev;
  end

  assign edge_det = armed ? raw_edge : '0;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && address == 2'd2) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Set is OR-ed in after the clear so a coincident edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
    end
  end

  assign irq = |(edgecapture & irqmask);

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = cond;
      2'd2:    rd_next[WIDTH-1:0] = irqmask;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_pio_in_edge.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_pio_in_edge
// Purpose  : Directed self-checking bench. dut uses default parameters
//            (WIDTH=4, falling edge); dut2 uses WIDTH=8, any edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_nios2_pio_in_edge;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        chipselect2;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [7:0]  in_port2;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic        irq;
  logic        irq2;

  int total = 0;
  int bad   = 0;

  nios2_pio_in_edge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  nios2_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect2),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port2),
    .readdata   (readdata2),
    .irq        (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic sel2);
    address     = a;
    writedata   = d;
    chipselect  = ~sel2;
    chipselect2 = sel2;
    write_n     = 1'b0;
    tick();
    chipselect  = 1'b0;
    chipselect2 = 1'b0;
    write_n     = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    address     = 2'd0;
    chipselect  = 1'b0;
    chipselect2 = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'h0;
    in_port     = 4'hF;
    in_port2    = 8'h00;

    // Reset state
    repeat (3) tick();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // Input held high through reset and 10 cycles after release
    reset_n = 1'b1;
    repeat (10) tick();
    bus_read(2'd3);
    check("idle_edgecapture", readdata, 32'h0);
    check("idle_irq", {31'h0, irq}, 32'h0);
    bus_read(2'd0);
    check("idle_data", readdata, 32'hF);

    // Falling edge on bit 1 with irqmask=2
    bus_write(2'd2, 32'h2, 1'b0);
    bus_read(2'd2);
    check("irqmask_rd", readdata, 32'h2);
    in_port = 4'hD;
    repeat (2) tick();
    check("irq_before_edge", {31'h0, irq}, 32'h0);
    tick();
    check("irq_after_edge", {31'h0, irq}, 32'h1);
    bus_read(2'd3);
    check("edgecapture_bit1", readdata, 32'h2);
    bus_write(2'd3, 32'h2, 1'b0);
    check("irq_after_clear", {31'h0, irq}, 32'h0);
    bus_read(2'd3);
    check("edgecapture_cleared", readdata, 32'h0);

    // Writes to data/reserved are ignored; reserved reads 0
    bus_write(2'd1, 32'hFFFF_FFFF, 1'b0);
    bus_write(2'd0, 32'h0, 1'b0);
    bus_read(2'd1);
    check("reserved_rd", readdata, 32'h0);
    bus_read(2'd0);
    check("data_after_wr0", readdata, 32'hD);

    // Upper writedata bits ignored
    bus_write(2'd2, 32'hFFFF_FFF5, 1'b0);
    bus_read(2'd2);
    check("irqmask_width", readdata, 32'h5);

    // Clear of bit 0 in the same cycle its falling edge is detected
    in_port = 4'hC;
    repeat (2) tick();
    bus_write(2'd3, 32'h1, 1'b0);
    bus_read(2'd3);
    check("set_wins_clear", readdata, 32'h1);
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    bus_write(2'd3, 32'h1, 1'b0);
    check("irq_cleared_bit0", {31'h0, irq}, 32'h0);

    // Rising edges are not captured in the falling-edge build
    in_port = 4'hF;
    repeat (5) tick();
    bus_read(2'd3);
    check("rising_ignored", readdata, 32'h0);

    // Any-edge instance: two toggles on bit 7, irqmask 0
    in_port2 = 8'h80;
    repeat (5) tick();
    in_port2 = 8'h00;
    repeat (5) tick();
    bus_read(2'd3);
    check("dut2_edgecapture", readdata2, 32'h80);
    check("dut2_irq", {31'h0, irq2}, 32'h0);
    bus_read(2'd1);
    check("dut2_reserved", readdata2, 32'h0);

    // All four bits fall, then reset mid-operation
    bus_write(2'd2, 32'hF, 1'b0);
    in_port = 4'h0;
    repeat (5) tick();
    bus_read(2'd3);
    check("all_fall_capture", readdata, 32'hF);
    check("all_fall_irq", {31'h0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq2", {31'h0, irq2}, 32'h0);
    in_port  = 4'hF;
    in_port2 = 8'hFF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    bus_read(2'd3);
    check("rearm_edgecapture", readdata, 32'h0);
    check("rearm_edgecapture2", readdata2, 32'h0);
    check("rearm_irq2", {31'h0, irq2}, 32'h0);
    bus_read(2'd2);
    check("rearm_irqmask", readdata, 32'h0);
    bus_read(2'd0);
    check("rearm_data", readdata, 32'hF);
    check("rearm_data2", readdata2, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
